// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: FSM states, forward selects
// and the hardwired-zero register number.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-select for one source operand: picks the youngest stage that
// writes the source register, EX first, then MEM, then WB.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  logic [4:0] rd_ex_i,
  input  logic       rf_le_ex_i,
  input  logic [4:0] rd_mem_i,
  input  logic       rf_le_mem_i,
  input  logic [4:0] rd_wb_i,
  input  logic       rf_le_wb_i,
  output logic [1:0] fwd_o
);

  logic srcValid;
  logic hitEx;
  logic hitMem;
  logic hitWb;

  // Register zero is hardwired, so it never needs a forwarded value.
  assign srcValid = use_i && (src_i != REG_ZERO);
  assign hitEx    = srcValid && rf_le_ex_i  && (rd_ex_i  == src_i);
  assign hitMem   = srcValid && rf_le_mem_i && (rd_mem_i == src_i);
  assign hitWb    = srcValid && rf_le_wb_i  && (rd_wb_i  == src_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (hitEx) begin
      fwd_o = FWD_EX;
    end else if (hitMem) begin
      fwd_o = FWD_MEM;
    end else if (hitWb) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, branch flush, operand
// forwarding selects and a saturating count of stalled cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RA_ID,
  input  logic [4:0]       RB_ID,
  input  logic [4:0]       RD_ID,
  input  logic             A_S_ID,
  input  logic             B_S_ID,
  input  logic             D_S_ID,
  input  logic             ID_NOP_ID,
  input  logic [4:0]       RD_EX,
  input  logic             RF_LE_EX,
  input  logic             L_EX,
  input  logic [4:0]       RD_MEM,
  input  logic             RF_LE_MEM,
  input  logic [4:0]       RD_WB,
  input  logic             RF_LE_WB,
  input  logic             BR_FLUSH_EX,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [1:0]       FWD_D,
  output logic             STALLING,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic useA, useB, useD;
  logic loadUse;
  logic pcLe, ifIdLe, ifIdFlush, idExFlush, stallNow;
  logic [1:0] fwdA, fwdB, fwdD;

  assign useA = A_S_ID && !ID_NOP_ID;
  assign useB = B_S_ID && !ID_NOP_ID;
  assign useD = D_S_ID && !ID_NOP_ID;

  assign loadUse = L_EX && RF_LE_EX && (RD_EX != REG_ZERO) &&
                   ((useA && (RA_ID == RD_EX)) ||
                    (useB && (RB_ID == RD_EX)) ||
                    (useD && (RD_ID == RD_EX)));

  hazard_ctrl_fwd_sel u_fwd_a (
    .src_i(RA_ID), .use_i(useA),
    .rd_ex_i(RD_EX), .rf_le_ex_i(RF_LE_EX),
    .rd_mem_i(RD_MEM), .rf_le_mem_i(RF_LE_MEM),
    .rd_wb_i(RD_WB), .rf_le_wb_i(RF_LE_WB),
    .fwd_o(fwdA)
  );

  hazard_ctrl_fwd_sel u_fwd_b (
    .src_i(RB_ID), .use_i(useB),
    .rd_ex_i(RD_EX), .rf_le_ex_i(RF_LE_EX),
    .rd_mem_i(RD_MEM), .rf_le_mem_i(RF_LE_MEM),
    .rd_wb_i(RD_WB), .rf_le_wb_i(RF_LE_WB),
    .fwd_o(fwdB)
  );

  hazard_ctrl_fwd_sel u_fwd_d (
    .src_i(RD_ID), .use_i(useD),
    .rd_ex_i(RD_EX), .rf_le_ex_i(RF_LE_EX),
    .rd_mem_i(RD_MEM), .rf_le_mem_i(RF_LE_MEM),
    .rd_wb_i(RD_WB), .rf_le_wb_i(RF_LE_WB),
    .fwd_o(fwdD)
  );

  // A branch always wins, even over a (supposedly impossible) branch in STALL.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcLe      = 1'b1;
    ifIdLe    = 1'b1;
    ifIdFlush = 1'b0;
    idExFlush = 1'b0;
    stallNow  = 1'b0;
    if (BR_FLUSH_EX) begin
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
      state_d   = RUN;
      cnt_d     = 3'd0;
    end else if (state_q == STALL) begin
      pcLe      = 1'b0;
      ifIdLe    = 1'b0;
      idExFlush = 1'b1;
      stallNow  = 1'b1;
      cnt_d     = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = RUN;
      end
    end else if (loadUse) begin
      pcLe      = 1'b0;
      ifIdLe    = 1'b0;
      idExFlush = 1'b1;
      stallNow  = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = STALL;
        cnt_d   = LAT_M1;
      end
    end
  end

  // Reset forces a frozen, fully flushed pipeline regardless of state.
  assign PC_LE       = reset && pcLe;
  assign IF_ID_LE    = reset && ifIdLe;
  assign IF_ID_FLUSH = !reset || ifIdFlush;
  assign ID_EX_FLUSH = !reset || idExFlush;
  assign STALLING    = reset && stallNow;
  assign FWD_A       = reset ? fwdA : FWD_RF;
  assign FWD_B       = reset ? fwdB : FWD_RF;
  assign FWD_D       = reset ? fwdD : FWD_RF;
  assign STALL_CNT   = stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (STALLING && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_LAT=1 and a 2-bit
// counter (to reach saturation), one with LOAD_LAT=3.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic resetN;
  logic [4:0] raId, rbId, rdId, rdEx, rdMem, rdWb;
  logic aS, bS, dS, nopId, rfLeEx, lEx, rfLeMem, rfLeWb, brFlush;

  logic pcLe1, ifIdLe1, ifIdFlush1, idExFlush1, stall1;
  logic [1:0] fwdA1, fwdB1, fwdD1;
  logic [1:0] stallCnt1;
  logic pcLe3, ifIdLe3, ifIdFlush3, idExFlush3, stall3;
  logic [1:0] fwdA3, fwdB3, fwdD3;
  logic [15:0] stallCnt3;

  int testCount = 0;
  int failCount = 0;
  int stallRun;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(resetN),
    .RA_ID(raId), .RB_ID(rbId), .RD_ID(rdId),
    .A_S_ID(aS), .B_S_ID(bS), .D_S_ID(dS), .ID_NOP_ID(nopId),
    .RD_EX(rdEx), .RF_LE_EX(rfLeEx), .L_EX(lEx),
    .RD_MEM(rdMem), .RF_LE_MEM(rfLeMem),
    .RD_WB(rdWb), .RF_LE_WB(rfLeWb), .BR_FLUSH_EX(brFlush),
    .PC_LE(pcLe1), .IF_ID_LE(ifIdLe1), .IF_ID_FLUSH(ifIdFlush1),
    .ID_EX_FLUSH(idExFlush1), .FWD_A(fwdA1), .FWD_B(fwdB1), .FWD_D(fwdD1),
    .STALLING(stall1), .STALL_CNT(stallCnt1)
  );

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(resetN),
    .RA_ID(raId), .RB_ID(rbId), .RD_ID(rdId),
    .A_S_ID(aS), .B_S_ID(bS), .D_S_ID(dS), .ID_NOP_ID(nopId),
    .RD_EX(rdEx), .RF_LE_EX(rfLeEx), .L_EX(lEx),
    .RD_MEM(rdMem), .RF_LE_MEM(rfLeMem),
    .RD_WB(rdWb), .RF_LE_WB(rfLeWb), .BR_FLUSH_EX(brFlush),
    .PC_LE(pcLe3), .IF_ID_LE(ifIdLe3), .IF_ID_FLUSH(ifIdFlush3),
    .ID_EX_FLUSH(idExFlush3), .FWD_A(fwdA3), .FWD_B(fwdB3), .FWD_D(fwdD3),
    .STALLING(stall3), .STALL_CNT(stallCnt3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    {raId, rbId, rdId, rdEx, rdMem, rdWb} = '0;
    {aS, bS, dS, nopId, rfLeEx, lEx, rfLeMem, rfLeWb, brFlush} = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Load in EX writing r7, ID instruction reads r7 through RB.
  task automatic applyStimulus();
    clearInputs();
    lEx = 1'b1; rfLeEx = 1'b1; rdEx = 5'd7; rbId = 5'd7; bS = 1'b1;
  endtask

  initial begin
    clearInputs();
    resetN = 1'b0;
    raId = 5'd5; aS = 1'b1; rdEx = 5'd5; rfLeEx = 1'b1;
    #2;
    checkOutput("rst_pc_le", pcLe1, 0);
    checkOutput("rst_if_id_le", ifIdLe1, 0);
    checkOutput("rst_if_id_flush", ifIdFlush1, 1);
    checkOutput("rst_id_ex_flush", idExFlush3, 1);
    checkOutput("rst_fwd_a", fwdA1, 2'b00);
    checkOutput("rst_stalling", stall3, 0);
    checkOutput("rst_stall_cnt", stallCnt3, 0);

    @(negedge clk);
    resetN = 1'b1;
    clearInputs();
    #1;
    checkOutput("run_pc_le", pcLe1, 1);
    checkOutput("run_if_id_le", ifIdLe3, 1);
    checkOutput("run_if_id_flush", ifIdFlush1, 0);
    checkOutput("run_id_ex_flush", idExFlush1, 0);

    raId = 5'd5; aS = 1'b1; rdEx = 5'd5; rfLeEx = 1'b1; rdMem = 5'd5; rfLeMem = 1'b1;
    #1;
    checkOutput("fwd_a_ex", fwdA1, 2'b01);
    checkOutput("fwd_no_stall", stall1, 0);
    rfLeEx = 1'b0;
    #1;
    checkOutput("fwd_a_mem", fwdA1, 2'b10);
    rfLeMem = 1'b0; rdWb = 5'd5; rfLeWb = 1'b1; rbId = 5'd5; rdId = 5'd5; dS = 1'b1;
    #1;
    checkOutput("fwd_a_wb", fwdA1, 2'b11);
    checkOutput("fwd_b_unused", fwdB1, 2'b00);
    checkOutput("fwd_d_wb", fwdD3, 2'b11);

    clearInputs();
    lEx = 1'b1; rfLeEx = 1'b1; aS = 1'b1;
    #1;
    checkOutput("r0_no_stall", stall1, 0);
    checkOutput("r0_fwd_a", fwdA1, 2'b00);
    checkOutput("r0_pc_le", pcLe3, 1);
    rdEx = 5'd7; raId = 5'd7; nopId = 1'b1;
    #1;
    checkOutput("nop_no_stall", stall3, 0);
    checkOutput("nop_fwd_a", fwdA3, 2'b00);

    nextCycle();
    applyStimulus();
    brFlush = 1'b1;
    #1;
    checkOutput("br_if_id_flush", ifIdFlush3, 1);
    checkOutput("br_id_ex_flush", idExFlush3, 1);
    checkOutput("br_pc_le", pcLe3, 1);
    checkOutput("br_stalling", stall3, 0);
    nextCycle();
    clearInputs();
    #1;
    checkOutput("br_stays_run", pcLe3, 1);
    checkOutput("br_no_count", stallCnt3, 0);

    // LOAD_LAT=1: single bubble, then the consumer forwards from MEM.
    nextCycle();
    applyStimulus();
    #1;
    checkOutput("lu1_pc_le", pcLe1, 0);
    checkOutput("lu1_if_id_le", ifIdLe1, 0);
    checkOutput("lu1_id_ex_flush", idExFlush1, 1);
    checkOutput("lu1_stalling", stall1, 1);
    nextCycle();
    clearInputs();
    rbId = 5'd7; bS = 1'b1; rdMem = 5'd7; rfLeMem = 1'b1;
    #1;
    checkOutput("lu1_resume", pcLe1, 1);
    checkOutput("lu1_stall_cnt", stallCnt1, 2'd1);
    checkOutput("lu1_fwd_b_mem", fwdB1, 2'b10);

    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus();
      nextCycle();
      clearInputs();
    end
    #1;
    checkOutput("cnt_saturates", stallCnt1, 2'd3);

    resetN = 1'b0;
    #1;
    checkOutput("rst2_stall_cnt", stallCnt3, 0);
    @(negedge clk);
    resetN = 1'b1;

    // LOAD_LAT=3: three consecutive bubbles; EX holds a bubble after the first.
    nextCycle();
    applyStimulus();
    #1;
    stallRun = 0;
    for (int i = 0; i < 10; i++) begin
      if (!stall3) break;
      stallRun++;
      checkOutput("lu3_pc_le_low", pcLe3, 0);
      nextCycle();
      clearInputs();
      #1;
    end
    checkOutput("lu3_stall_cycles", stallRun, 3);
    checkOutput("lu3_resume", pcLe3, 1);
    checkOutput("lu3_stall_cnt", stallCnt3, 3);

    nextCycle();
    applyStimulus();
    #1;
    checkOutput("mid_stall1", stall3, 1);
    nextCycle();
    clearInputs();
    #1;
    checkOutput("mid_stall2", stall3, 1);
    resetN = 1'b0;
    #1;
    checkOutput("mid_rst_pc_le", pcLe3, 0);
    checkOutput("mid_rst_if_id_flush", ifIdFlush3, 1);
    checkOutput("mid_rst_stalling", stall3, 0);
    checkOutput("mid_rst_stall_cnt", stallCnt3, 0);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    checkOutput("post_rst_pc_le", pcLe3, 1);
    nextCycle();
    checkOutput("post_rst_run", stall3, 0);
    checkOutput("post_rst_if_id_le", ifIdLe3, 1);
    checkOutput("post_rst_stall_cnt", stallCnt3, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
